tpu_operand_loader: RTL and testbench

Upstream feeder for the TPU core. It accepts a run configuration (K, M, N) from the host, then takes operand words from a 32-bit AXI-Stream slave and writes them in order into global buffer A, then global buffer B. When both buffers are full it launches the TPU with a one-cycle `in_valid` pulse, waits for `ap_done`, and returns to idle. It sits between the host DMA stream and the TPU's A/B global-buffer write ports and start/config inputs.

---
 rtl/tpu_pkg.sv | 35 +++
 rtl/ldr_beat_counter.sv | 42 ++++
 rtl/tpu_operand_loader.sv | 196 +++++++++++++++++++
 tb/tb_tpu_operand_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared constants, state encoding and helpers for the TPU
//               operand loader slice.
//               ADDR_BITS  - global-buffer index width
//               DATA_BITS  - stream / buffer word width
//               LANE_COUNT - 8-bit lanes packed per word
//               LANE_BITS  - width of one lane
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int ADDR_BITS  = 16;
  localparam int DATA_BITS  = 32;
  localparam int LANE_COUNT = 4;
  localparam int LANE_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_WAIT   = 3'd4
  } ldr_state_t;

  // Words needed to hold one row of 'dim' 8-bit elements, rounded up.
  function automatic logic [7:0] lane_words(input logic [7:0] dim);
    logic [8:0] w_sum;
    w_sum = {1'b0, dim} + 9'(LANE_COUNT - 1);
    return 8'(w_sum >> $clog2(LANE_COUNT));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldr_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : ldr_beat_counter
// Description : Beat counter with synchronous clear, count enable and a
//               terminal-value compare. Shared by the A and B load phases.
// Ports       : clk, rst_n      clock / async active-low reset
//               i_clr           force count to zero (wins over i_en)
//               i_en            advance count by one
//               i_term          terminal value for the compare
//               o_count         current count
//               o_at_term       count equals i_term
// Revision    : 1.0 - initial release
// ============================================================================
module ldr_beat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_term
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_count   = r_count;
  assign o_at_term = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/tpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tpu_operand_loader
// Description : Takes a (K, M, N) run configuration, streams K*ceil(M/4)
//               words into global buffer A then K*ceil(N/4) words into
//               global buffer B from a 32-bit AXI-Stream slave, launches the
//               TPU with a one-cycle pulse and waits for its completion.
// Ports       : clk, rst_n                  clock / async active-low reset
//               cfg_start, cfg_K/M/N        run request and dimensions
//               cfg_busy, cfg_done, cfg_err run status
//               ss_tvalid/tdata/tlast/tready operand stream slave
//               A_/B_ wr_en, index, data_in global-buffer write ports
//               tpu_in_valid, tpu_K/M/N     TPU start and latched dimensions
//               tpu_ap_done                 TPU completion
// Options     : LOADER_TLAST_CHECK_EN - when defined, flag any beat whose
//               ss_tlast disagrees with "final B beat" in sticky cfg_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_operand_loader
  import tpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [7:0]           cfg_K,
  input  logic [7:0]           cfg_M,
  input  logic [7:0]           cfg_N,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  input  logic                 ss_tvalid,
  input  logic [DATA_BITS-1:0] ss_tdata,
  input  logic                 ss_tlast,
  output logic                 ss_tready,
  output logic                 A_wr_en,
  output logic [ADDR_BITS-1:0] A_index,
  output logic [DATA_BITS-1:0] A_data_in,
  output logic                 B_wr_en,
  output logic [ADDR_BITS-1:0] B_index,
  output logic [DATA_BITS-1:0] B_data_in,
  output logic                 tpu_in_valid,
  output logic [7:0]           tpu_K,
  output logic [7:0]           tpu_M,
  output logic [7:0]           tpu_N,
  input  logic                 tpu_ap_done
);

  ldr_state_t r_state;
  ldr_state_t w_state_nxt;

  logic [7:0]           r_k, r_m, r_n;
  logic [ADDR_BITS-1:0] r_a_len, r_b_len;
  logic                 r_a_wr_en, r_b_wr_en;
  logic [ADDR_BITS-1:0] r_a_index, r_b_index;
  logic [DATA_BITS-1:0] r_a_data, r_b_data;
  logic                 r_in_valid, r_done;

  logic                 w_start_ok, w_in_a, w_in_b, w_beat;
  logic                 w_last_beat, w_cnt_clr;
  logic [ADDR_BITS-1:0] w_cnt, w_term, w_a_len, w_b_len;

  assign w_start_ok = (r_state == ST_IDLE) && cfg_start &&
                      (cfg_K != 8'd0) && (cfg_M != 8'd0) && (cfg_N != 8'd0);
  assign w_in_a     = (r_state == ST_LOAD_A);
  assign w_in_b     = (r_state == ST_LOAD_B);
  assign w_beat     = ss_tvalid && (w_in_a || w_in_b);

  // 255 * 64 = 16320 fits comfortably in 16 bits.
  assign w_a_len = ADDR_BITS'(cfg_K) * ADDR_BITS'(lane_words(cfg_M));
  assign w_b_len = ADDR_BITS'(cfg_K) * ADDR_BITS'(lane_words(cfg_N));

  // Lengths are never zero once latched, so length-1 is a valid index.
  assign w_term    = w_in_a ? (r_a_len - 1'b1) : (r_b_len - 1'b1);
  // Clearing on the last A beat lets B start at index 0 with no bubble.
  assign w_cnt_clr = w_start_ok || (w_beat && w_in_a && w_last_beat);

  ldr_beat_counter #(
    .WIDTH (ADDR_BITS)
  ) u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_cnt_clr),
    .i_en      (w_beat),
    .i_term    (w_term),
    .o_count   (w_cnt),
    .o_at_term (w_last_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok)             w_state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (w_beat && w_last_beat)  w_state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (w_beat && w_last_beat)  w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:                             w_state_nxt = ST_WAIT;
      ST_WAIT:   if (tpu_ap_done)            w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  // Run configuration, held until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_a_len <= '0;
      r_b_len <= '0;
    end else if (w_start_ok) begin
      r_k     <= cfg_K;
      r_m     <= cfg_M;
      r_n     <= cfg_N;
      r_a_len <= w_a_len;
      r_b_len <= w_b_len;
    end
  end

  // Buffer write ports: strobe is one cycle per beat, index/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_wr_en <= 1'b0;
      r_a_index <= '0;
      r_a_data  <= '0;
      r_b_wr_en <= 1'b0;
      r_b_index <= '0;
      r_b_data  <= '0;
    end else begin
      r_a_wr_en <= w_beat && w_in_a;
      r_b_wr_en <= w_beat && w_in_b;
      if (w_beat && w_in_a) begin
        r_a_index <= w_cnt;
        r_a_data  <= ss_tdata;
      end
      if (w_beat && w_in_b) begin
        r_b_index <= w_cnt;
        r_b_data  <= ss_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_valid <= (r_state == ST_LAUNCH);
      r_done     <= (r_state == ST_WAIT) && tpu_ap_done;
    end
  end

`ifdef LOADER_TLAST_CHECK_EN
  logic r_err;

  // TLAST must coincide exactly with the final B beat; counting goes on
  // regardless, the error is only reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_beat && (ss_tlast != (w_in_b && w_last_beat))) begin
      r_err <= 1'b1;
    end
  end

  assign cfg_err = r_err;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = ss_tlast;
  assign cfg_err        = 1'b0;
`endif

  assign cfg_busy     = (r_state != ST_IDLE);
  assign cfg_done     = r_done;
  assign ss_tready    = w_in_a || w_in_b;
  assign A_wr_en      = r_a_wr_en;
  assign A_index      = r_a_index;
  assign A_data_in    = r_a_data;
  assign B_wr_en      = r_b_wr_en;
  assign B_index      = r_b_index;
  assign B_data_in    = r_b_data;
  assign tpu_in_valid = r_in_valid;
  assign tpu_K        = r_k;
  assign tpu_M        = r_m;
  assign tpu_N        = r_n;

endmodule
`default_nettype wire

// File: tb/tb_tpu_operand_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tpu_operand_loader
// Description : Self-checking bench for tpu_operand_loader. Table of run
//               configurations plus randomized runs, compared against a
//               write-list model (index k of buffer X receives the k-th word
//               destined for X), and hand sequences for reset/idle corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_operand_loader;

`ifdef LOADER_TLAST_CHECK_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  cfg_K, cfg_M, cfg_N;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        A_wr_en, B_wr_en;
  logic [15:0] A_index, B_index;
  logic [31:0] A_data_in, B_data_in;
  logic        tpu_in_valid;
  logic [7:0]  tpu_K, tpu_M, tpu_N;
  logic        tpu_ap_done;

  always #5 clk = ~clk;

  tpu_operand_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_K        (cfg_K),
    .cfg_M        (cfg_M),
    .cfg_N        (cfg_N),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .ss_tvalid    (ss_tvalid),
    .ss_tdata     (ss_tdata),
    .ss_tlast     (ss_tlast),
    .ss_tready    (ss_tready),
    .A_wr_en      (A_wr_en),
    .A_index      (A_index),
    .A_data_in    (A_data_in),
    .B_wr_en      (B_wr_en),
    .B_index      (B_index),
    .B_data_in    (B_data_in),
    .tpu_in_valid (tpu_in_valid),
    .tpu_K        (tpu_K),
    .tpu_M        (tpu_M),
    .tpu_N        (tpu_N),
    .tpu_ap_done  (tpu_ap_done)
  );

  typedef struct packed { logic [15:0] idx; logic [31:0] data; } wr_t;
  typedef struct {
    int k, m, n, gap, tlast, busy_at, alen, blen;
    bit err;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   run_id   = 0;
  wr_t  qa[$], qb[$];
  int   launch_cnt, done_cnt, dim_bad;
  time  launch_t;
  bit   done_busy;
  bit   mon_dims = 1'b0;
  logic [7:0] exp_k, exp_m, exp_n;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (A_wr_en) qa.push_back({A_index, A_data_in});
    if (B_wr_en) qb.push_back({B_index, B_data_in});
    if (tpu_in_valid) begin
      launch_cnt++;
      launch_t = $time;
    end
    if (cfg_done) begin
      done_cnt++;
      done_busy = cfg_busy;
    end
    if (mon_dims && cfg_busy && ({tpu_K, tpu_M, tpu_N} != {exp_k, exp_m, exp_n}))
      dim_bad++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (run %0d): got %0h expected %0h", name, run_id, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A_port"}, longint'({A_wr_en, A_index, A_data_in}), 0);
    check({tag, "_B_port"}, longint'({B_wr_en, B_index, B_data_in}), 0);
    check({tag, "_ctl"}, longint'({cfg_busy, cfg_done, cfg_err, ss_tready, tpu_in_valid}), 0);
    check({tag, "_dims"}, longint'({tpu_K, tpu_M, tpu_N}), 0);
  endtask

  // Reference: words needed for a row of d bytes, i.e. ceil(d/4).
  function automatic int row_words(input int d);
    int w = 0;
    while (w * 4 < d) w++;
    return w;
  endfunction

  task automatic do_run(input int k, input int m, input int n, input int gap,
                        input int tlast_pos, input int busy_at,
                        input int alen, input int blen,
                        input bit exp_err, input bit basic);
    logic [31:0] words[$];
    int  total, i, guard, mis;
    bit  acc;
    time t_last;

    total = alen + blen;
    if (basic) words = {32'hA0, 32'hA1, 32'hB0, 32'hB1};
    else for (int j = 0; j < total; j++) words.push_back($urandom);
    qa.delete(); qb.delete();
    launch_cnt = 0; done_cnt = 0; dim_bad = 0;

    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_K = 8'(k); cfg_M = 8'(m); cfg_N = 8'(n);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_K = 8'($urandom); cfg_M = 8'($urandom); cfg_N = 8'($urandom);
    check("start_busy", cfg_busy, 1);
    check("start_tready", ss_tready, 1);
    check("start_err_clear", cfg_err, 0);
    check("start_dims", longint'({tpu_K, tpu_M, tpu_N}), longint'({8'(k), 8'(m), 8'(n)}));
    exp_k = 8'(k); exp_m = 8'(m); exp_n = 8'(n);
    mon_dims = 1'b1;

    i = 0; guard = 0; t_last = 0;
    while (i < total && guard < total * 20 + 50) begin
      ss_tvalid = (int'($urandom_range(99)) >= gap);
      ss_tdata  = ss_tvalid ? words[i] : $urandom;
      ss_tlast  = (i == tlast_pos);
      cfg_start = (busy_at >= 0) && (i == busy_at);
      if (cfg_start) begin
        cfg_K = 8'd9; cfg_M = 8'd9; cfg_N = 8'd9;
      end
      @(negedge clk);
      acc = ss_tvalid && ss_tready;
      @(posedge clk);
      if (acc) begin
        if (i == total - 1) t_last = $time;
        i++;
      end
      guard++;
      #1;
    end
    ss_tvalid = 1'b0; ss_tlast = 1'b0; cfg_start = 1'b0;
    check("beats_accepted", i, total);
    check("tready_after_last", ss_tready, 0);

    for (int w = 0; w < 12 && launch_cnt == 0; w++) begin
      @(negedge clk); #1;
    end
    check("launch_count", launch_cnt, 1);
    check("launch_delay_ns", longint'(launch_t - t_last), 15);
    check("busy_in_wait", cfg_busy, 1);
    check("tlast_err", cfg_err, longint'(exp_err));

    repeat ($urandom_range(2)) @(posedge clk);
    @(posedge clk); #1; tpu_ap_done = 1'b1;
    @(posedge clk); #1; tpu_ap_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_dims = 1'b0;
    check("done_count", done_cnt, 1);
    check("busy_at_done", done_busy, 0);
    check("idle_after_done", cfg_busy, 0);
    check("launch_once", launch_cnt, 1);
    check("dims_stable", dim_bad, 0);

    check("A_write_count", qa.size(), alen);
    mis = 0;
    for (int j = 0; j < qa.size() && j < alen; j++)
      if (qa[j].idx != 16'(j) || qa[j].data != words[j]) mis++;
    check("A_content_errs", mis, 0);
    check("B_write_count", qb.size(), blen);
    mis = 0;
    for (int j = 0; j < qb.size() && j < blen; j++)
      if (qb[j].idx != 16'(j) || qb[j].data != words[alen + j]) mis++;
    check("B_content_errs", mis, 0);
    run_id++;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2, 4, 4, 0, 3, -1, 2, 2, 1'b0};
    vecs[1] = '{3, 5, 1, 40, 8, -1, 6, 3, 1'b0};
    vecs[2] = '{1, 1, 1, 0, 1, -1, 1, 1, 1'b0};
    vecs[3] = '{2, 4, 4, 0, 1, -1, 2, 2, 1'b1};
    vecs[4] = '{1, 8, 3, 20, -1, -1, 2, 1, 1'b1};
    vecs[5] = '{4, 7, 9, 30, 19, -1, 8, 12, 1'b0};
    vecs[6] = '{2, 4, 8, 25, 5, 3, 2, 4, 1'b0};
    vecs[7] = '{255, 255, 1, 0, 16574, -1, 16320, 255, 1'b0};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_K = 8'd0; cfg_M = 8'd0; cfg_N = 8'd0;
    ss_tvalid = 1'b0; ss_tdata = 32'd0; ss_tlast = 1'b0; tpu_ap_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Stray completion while idle must not produce cfg_done.
    done_cnt = 0;
    @(posedge clk); #1; tpu_ap_done = 1'b1;
    @(posedge clk); #1; tpu_ap_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_ap_done", done_cnt, 0);

    // A zero dimension in any position leaves the loader idle.
    for (int z = 0; z < 3; z++) begin
      @(posedge clk); #1;
      cfg_start = 1'b1;
      cfg_K = (z == 0) ? 8'd0 : 8'd3;
      cfg_M = (z == 1) ? 8'd0 : 8'd3;
      cfg_N = (z == 2) ? 8'd0 : 8'd3;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      check("zero_dim_busy", cfg_busy, 0);
      check("zero_dim_tready", ss_tready, 0);
    end

    foreach (vecs[v])
      do_run(vecs[v].k, vecs[v].m, vecs[v].n, vecs[v].gap, vecs[v].tlast,
             vecs[v].busy_at, vecs[v].alen, vecs[v].blen,
             TLAST_ON && vecs[v].err, v == 0);

    // Reset in the middle of loading A, then a clean run from index 0.
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_K = 8'd2; cfg_M = 8'd8; cfg_N = 8'd4;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    ss_tvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      ss_tdata = 32'h100 + 32'(b);
      @(posedge clk); #1;
    end
    ss_tvalid = 1'b0;
    check("pre_reset_A_wr_en", A_wr_en, 1);
    check("pre_reset_A_index", A_index, 2);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_run(2, 4, 4, 0, 3, -1, 2, 2, 1'b0, 1'b1);

    // Randomized runs; lengths come from the ceil-division model.
    for (int r = 0; r < 6; r++) begin
      int k, m, n, al, bl;
      k  = int'($urandom_range(1, 12));
      m  = int'($urandom_range(1, 40));
      n  = int'($urandom_range(1, 40));
      al = k * row_words(m);
      bl = k * row_words(n);
      do_run(k, m, n, int'($urandom_range(0, 50)), al + bl - 1, -1, al, bl, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
